// File: rtl/axi_lite_buf.sv
// Ready/valid FIFO with registered in_rdy (!full) and out_vld (!empty); DEPTH=0 wires straight through.
// Latency: a beat pushed at edge N is presented after edge N; zero cycles when DEPTH=0.
// Backpressure: in_rdy comes from a register with no combinational path from out_rdy.
module axi_lite_buf_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_vld,
  output logic             in_rdy,
  input  logic [WIDTH-1:0] in_dat,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [WIDTH-1:0] out_dat
);
  if (DEPTH == 0) begin : g_pass
    assign out_vld = in_vld;
    assign in_rdy  = out_rdy;
    assign out_dat = in_dat;
  end else begin : g_fifo
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [WIDTH-1:0] mem [2**PW];
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic             rdy_q, vld_q, push, pop;

    assign push = in_vld & rdy_q;
    assign pop  = vld_q & out_rdy;

    always_comb begin
      cnt_nxt = cnt;
      if (push && !pop)      cnt_nxt = cnt + 1'b1;
      else if (pop && !push) cnt_nxt = cnt - 1'b1;
    end

    // Pointers wrap explicitly so non-power-of-2 depths work.
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        cnt    <= '0;
        rdy_q  <= 1'b0;
        vld_q  <= 1'b0;
        for (int i = 0; i < 2**PW; i++) mem[i] <= '0;
      end else begin
        cnt   <= cnt_nxt;
        rdy_q <= (cnt_nxt != FULL);
        vld_q <= (cnt_nxt != '0);
        if (push) begin
          mem[wr_ptr] <= in_dat;
          wr_ptr      <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
        end
        if (pop) rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
      end
    end

    assign in_rdy  = rdy_q;
    assign out_vld = vld_q;
    assign out_dat = mem[rd_ptr];
  end
endmodule

// Outstanding-transaction counter: counts issue handshakes minus completion handshakes.
// Latency: gate reflects the registered count, updated one edge after the handshakes.
// Backpressure: gate=1 while the count sits at MAX; the caller blocks further issues.
module axi_lite_buf_limit #(
  parameter int MAX = 1
) (
  input  logic clk,
  input  logic rstn,
  input  logic inc,
  input  logic dec,
  output logic gate
);
  localparam int CW = $clog2(MAX + 1);
  localparam logic [CW-1:0] TOP = CW'(MAX);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                           cnt <= '0;
    else if (inc && !dec)                cnt <= cnt + 1'b1;
    else if (dec && !inc && cnt != '0)   cnt <= cnt - 1'b1;
  end

  assign gate = (cnt == TOP);

  // A completion with nothing outstanding means the downstream slave broke protocol.
  assert property (@(posedge clk) disable iff (!rstn) !(dec && cnt == '0));
endmodule

// AXI-Lite buffer: independent FIFO per channel plus optional read/write outstanding limiters.
// Latency: 1 cycle per buffered channel, 0 for DEPTH=0 channels.
// Backpressure: slave-side readies are registered !full; AR/AW stall while their limiter is saturated.
module axi_lite_buf #(
  parameter int ADDR_WIDTH = 48,
  parameter int DATA_WIDTH = 64,
  parameter int AW_DEPTH   = 2,
  parameter int W_DEPTH    = 2,
  parameter int B_DEPTH    = 2,
  parameter int AR_DEPTH   = 2,
  parameter int R_DEPTH    = 2,
  parameter int MAX_RD_OUT = 0,
  parameter int MAX_WR_OUT = 0
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    slave_aw_vld,
  output logic                    slave_aw_rdy,
  input  logic [ADDR_WIDTH-1:0]   slave_aw_addr,
  input  logic [2:0]              slave_aw_prot,
  input  logic                    slave_w_vld,
  output logic                    slave_w_rdy,
  input  logic [DATA_WIDTH-1:0]   slave_w_dat,
  input  logic [DATA_WIDTH/8-1:0] slave_w_strb,
  output logic                    slave_b_vld,
  input  logic                    slave_b_rdy,
  output logic [1:0]              slave_b_resp,
  input  logic                    slave_ar_vld,
  output logic                    slave_ar_rdy,
  input  logic [ADDR_WIDTH-1:0]   slave_ar_addr,
  input  logic [2:0]              slave_ar_prot,
  output logic                    slave_r_vld,
  input  logic                    slave_r_rdy,
  output logic [DATA_WIDTH-1:0]   slave_r_dat,
  output logic [1:0]              slave_r_resp,
  output logic                    master_aw_vld,
  input  logic                    master_aw_rdy,
  output logic [ADDR_WIDTH-1:0]   master_aw_addr,
  output logic [2:0]              master_aw_prot,
  output logic                    master_w_vld,
  input  logic                    master_w_rdy,
  output logic [DATA_WIDTH-1:0]   master_w_dat,
  output logic [DATA_WIDTH/8-1:0] master_w_strb,
  input  logic                    master_b_vld,
  output logic                    master_b_rdy,
  input  logic [1:0]              master_b_resp,
  output logic                    master_ar_vld,
  input  logic                    master_ar_rdy,
  output logic [ADDR_WIDTH-1:0]   master_ar_addr,
  output logic [2:0]              master_ar_prot,
  input  logic                    master_r_vld,
  output logic                    master_r_rdy,
  input  logic [DATA_WIDTH-1:0]   master_r_dat,
  input  logic [1:0]              master_r_resp
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  typedef struct packed { logic [ADDR_WIDTH-1:0] addr; logic [2:0] prot; } ax_t;
  typedef struct packed { logic [DATA_WIDTH-1:0] dat; logic [STRB_WIDTH-1:0] strb; } w_t;
  typedef struct packed { logic [DATA_WIDTH-1:0] dat; logic [1:0] resp; } r_t;

  ax_t  aw_out, ar_out;
  w_t   w_out;
  r_t   r_out;
  logic aw_vld, ar_vld, wr_gate, rd_gate;

  axi_lite_buf_fifo #(.WIDTH($bits(ax_t)), .DEPTH(AW_DEPTH)) u_aw (
    .clk, .rstn, .in_vld(slave_aw_vld), .in_rdy(slave_aw_rdy),
    .in_dat({slave_aw_addr, slave_aw_prot}), .out_vld(aw_vld),
    .out_rdy(master_aw_rdy & ~wr_gate), .out_dat(aw_out));

  axi_lite_buf_fifo #(.WIDTH($bits(w_t)), .DEPTH(W_DEPTH)) u_w (
    .clk, .rstn, .in_vld(slave_w_vld), .in_rdy(slave_w_rdy),
    .in_dat({slave_w_dat, slave_w_strb}), .out_vld(master_w_vld),
    .out_rdy(master_w_rdy), .out_dat(w_out));

  axi_lite_buf_fifo #(.WIDTH(2), .DEPTH(B_DEPTH)) u_b (
    .clk, .rstn, .in_vld(master_b_vld), .in_rdy(master_b_rdy),
    .in_dat(master_b_resp), .out_vld(slave_b_vld),
    .out_rdy(slave_b_rdy), .out_dat(slave_b_resp));

  axi_lite_buf_fifo #(.WIDTH($bits(ax_t)), .DEPTH(AR_DEPTH)) u_ar (
    .clk, .rstn, .in_vld(slave_ar_vld), .in_rdy(slave_ar_rdy),
    .in_dat({slave_ar_addr, slave_ar_prot}), .out_vld(ar_vld),
    .out_rdy(master_ar_rdy & ~rd_gate), .out_dat(ar_out));

  axi_lite_buf_fifo #(.WIDTH($bits(r_t)), .DEPTH(R_DEPTH)) u_r (
    .clk, .rstn, .in_vld(master_r_vld), .in_rdy(master_r_rdy),
    .in_dat({master_r_dat, master_r_resp}), .out_vld(slave_r_vld),
    .out_rdy(slave_r_rdy), .out_dat(r_out));

  // Gating only ever drops while the head is idle, so a raised valid is never withdrawn.
  assign master_aw_vld  = aw_vld & ~wr_gate;
  assign master_aw_addr = aw_out.addr;
  assign master_aw_prot = aw_out.prot;
  assign master_w_dat   = w_out.dat;
  assign master_w_strb  = w_out.strb;
  assign master_ar_vld  = ar_vld & ~rd_gate;
  assign master_ar_addr = ar_out.addr;
  assign master_ar_prot = ar_out.prot;
  assign slave_r_dat    = r_out.dat;
  assign slave_r_resp   = r_out.resp;

  if (MAX_WR_OUT > 0) begin : g_wr_lim
    axi_lite_buf_limit #(.MAX(MAX_WR_OUT)) u_wr_lim (
      .clk, .rstn, .inc(master_aw_vld & master_aw_rdy),
      .dec(master_b_vld & master_b_rdy), .gate(wr_gate));
  end else begin : g_wr_free
    assign wr_gate = 1'b0;
  end

  if (MAX_RD_OUT > 0) begin : g_rd_lim
    axi_lite_buf_limit #(.MAX(MAX_RD_OUT)) u_rd_lim (
      .clk, .rstn, .inc(master_ar_vld & master_ar_rdy),
      .dec(master_r_vld & master_r_rdy), .gate(rd_gate));
  end else begin : g_rd_free
    assign rd_gate = 1'b0;
  end
endmodule
